// File: rtl/fix2float_seq.sv
// fix2float_seq
//   Sequential signed fixed-point to IEEE-754 single-precision converter.
//   The operand is dataa * 2^-FRAC_BITS in two's complement. The magnitude is
//   normalised one bit per enabled cycle and then packed with round-to-nearest-even.
//
// Ports
//   clock   in   rising-edge clock
//   aclr_n  in   asynchronous active-low reset
//   clk_en  in   clock enable; every register holds while low
//   start   in   single-cycle request, dataa sampled on the accepting edge
//   dataa   in   WIDTH-bit signed fixed-point operand
//   result  out  IEEE-754 single, held from done until the next done
//   done    out  one enabled-cycle pulse when result is updated
//
// WIDTH must be at least 26 so that the fraction, guard and sticky fields exist.
// The parameters must keep the biased exponent within 1..254.
module fix2float_seq #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAC_BITS = 22
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic             clk_en,
  input  logic             start,
  input  logic [WIDTH-1:0] dataa,
  output logic [31:0]      result,
  output logic             done
);

  localparam int unsigned CW      = $clog2(WIDTH) + 1;
  // Biased exponent when the magnitude MSB already sits in bit WIDTH-1.
  localparam int unsigned EXP_TOP = WIDTH - 1 - FRAC_BITS + 127;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    PACK
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic [31:0]      result_q, result_d;
  logic             done_q, done_d;

  // Absolute value; the most negative input maps to 2^(WIDTH-1) as unsigned.
  logic [WIDTH-1:0] mag_in;
  assign mag_in = dataa[WIDTH-1] ? (~dataa + WIDTH'(1)) : dataa;

  // Pack stage: fraction, guard and sticky taken from the normalised magnitude.
  logic [22:0] frac;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] frac_rnd;
  logic [7:0]  exp_base;
  logic [7:0]  exp_final;

  assign frac      = mag_q[WIDTH-2 -: 23];
  assign guard     = mag_q[WIDTH-25];
  assign sticky    = |mag_q[WIDTH-26:0];
  assign round_up  = guard & (sticky | frac[0]);
  assign frac_rnd  = {1'b0, frac} + 24'(round_up);
  // A carry out of the fraction leaves frac_rnd[22:0] all zero and bumps the exponent.
  assign exp_base  = 8'(EXP_TOP) - 8'(cnt_q);
  assign exp_final = exp_base + 8'(frac_rnd[23]);

  // State register
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= IDLE;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (mag_in == '0) ? PACK : NORM;
      NORM:    if (mag_q[WIDTH-1]) state_d = PACK;
      PACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    mag_d    = mag_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d = dataa[WIDTH-1];
          mag_d  = mag_in;
          cnt_d  = '0;
        end
      end
      NORM: begin
        if (!mag_q[WIDTH-1]) begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      PACK: begin
        done_d   = 1'b1;
        result_d = (mag_q == '0) ? '0 : {sign_q, exp_final, frac_rnd[22:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      mag_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (clk_en) begin
      mag_q    <= mag_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule
